alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
- Per-core control sequencer. It is the initiator side of the ALU interface: it drives the 3-bit ALU op code and consumes the ALU z flag.
- Fetches an opcode through a ready-handshake memory port, decodes it, and steps the datapath through the required states.
- Registers z for conditional jumps and counts retired instructions.
- Sits between the core's instruction register, PC, accumulator and the ALU.

Parameters:
- OPC_W, 8, opcode width presented on instr.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching.
- instr  in  OPC_W  opcode from the IR; valid from DECODE onwards.
- z  in  1  ALU flag: 1 when result is zero or negative (bit15 = 1).
- mem_ready  in  1  memory completes the current read/write this cycle.
- alu_op  out  3  ALU op code. 0 = no op (ALU holds its output); 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD, 6 XOR.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- mem_ifetch  out  1  qualifies mem_rd as an instruction fetch.
- ir_load  out  1  load IR from memory data.
- pc_inc  out  1  increment PC.
- pc_load  out  1  load PC from the operand register.
- ac_load  out  1  write accumulator.
- ac_src_mem  out  1  accumulator source: 1 = memory data, 0 = ALU output.
- z_flag  out  1  registered z.
- busy  out  1  state not IDLE and not HALT.
- halted  out  1  in HALT.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: state IDLE; all outputs 0; z_flag 0; retired 0. Reset is synchronous, active-high and overrides everything. Any in-flight memory request is dropped the next cycle.
- Outputs are combinational decodes of the registered state (Moore), except ir_load, pc_inc and ac_load in wait states, which are qualified by mem_ready.
- IDLE: start = 1 -> FETCH.
- FETCH: mem_rd = 1, mem_ifetch = 1.
  - Stay while mem_ready = 0.
  - On mem_ready = 1: ir_load = 1 and pc_inc = 1 that cycle -> DECODE.
- DECODE (1 cycle), by instr:
  - 0x00 NOP -> FETCH, retire.
  - 0x01..0x06 -> EXEC.
  - 0x10 LOAD, 0x11 STORE -> MEM.
  - 0x20 JMPZ: z_flag = 1 -> JUMP, else -> FETCH and retire.
  - 0x21 JMPNZ: inverse of JMPZ.
  - 0x22 JMP -> JUMP.
  - 0xFF HALT -> HALT, retire.
  - Any other opcode: see Optional Feature.
- EXEC (1 cycle): alu_op = instr[2:0] -> WB.
- WB (1 cycle): alu_op = 0 (ALU holds its result); ac_load = 1; ac_src_mem = 0; z_flag <= z; retire -> FETCH.
- MEM:
  - LOAD holds mem_rd = 1 (mem_ifetch = 0); STORE holds mem_wr = 1.
  - Wait until mem_ready = 1. On that cycle, LOAD also asserts ac_load = 1 and ac_src_mem = 1.
  - Then retire -> FETCH. z_flag is unchanged.
- JUMP (1 cycle): pc_load = 1; retire -> FETCH.
- HALT: halted = 1; start is ignored; only reset exits.
- alu_op is 0 in every state except EXEC. mem_rd and mem_wr are never both 1.
- retired increments by 1 on each retire. It wraps from 2^CNT_W-1 to 0.
- mem_ready outside FETCH/MEM is ignored. start while busy is ignored.

Optional Feature:
- Macro ALU_CTRL_SEQ_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE -> HALT, without retiring; extra output port illegal_op (1 bit) is set sticky at 1 until reset.
- Undefined: an undefined opcode is treated as NOP (retire -> FETCH) and the illegal_op port does not exist.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALU op constants: ALU_NOP = 0, ALU_ADD = 1 .. ALU_XOR = 6.
  - Opcode constants: OPC_NOP, OPC_LOAD, OPC_STORE, OPC_JMPZ, OPC_JMPNZ, OPC_JMP, OPC_HALT.
  - State enum: IDLE, FETCH, DECODE, EXEC, WB, MEM, JUMP, HALT.
- One natural sub-module, alu_ctrl_decode: combinational opcode -> {class, alu_op, is_legal}. The FSM and counter stay in the top module.

Test Plan:
- Reset, start = 1, instr 0x01 (ADD), mem_ready = 1 every cycle, z = 0:
  - FETCH ir_load = 1 / pc_inc = 1.
  - DECODE.
  - EXEC alu_op = 1.
  - WB alu_op = 0, ac_load = 1.
  - Back in FETCH; retired = 1, z_flag = 0.
- SUB with z = 1 in WB, then JMPZ (0x20): z_flag = 1, JUMP asserts pc_load = 1 for 1 cycle, retired = 2. Repeat with z = 0: no pc_load, JMPZ retires from DECODE.
- LOAD with mem_ready low for 3 cycles:
  - mem_rd = 1, mem_ifetch = 0 held 4 cycles.
  - ac_load = 1 and ac_src_mem = 1 only on the ready cycle.
  - STORE: mem_wr = 1 held the same way, mem_rd = 0 throughout.
- Assert reset while in MEM with mem_wr = 1: next cycle all outputs 0, IDLE, retired = 0, z_flag = 0.
- HALT (0xFF) then start pulses: halted = 1 stays, busy = 0, no memory requests.
- Opcode 0x07:
  - With ALU_CTRL_SEQ_ILLEGAL_TRAP_EN: HALT, illegal_op = 1, retired unchanged.
  - Without it: treated as NOP, retired + 1.
- Preload retired via 0xFFFF NOPs (CNT_W = 16): the next retire gives retired = 0x0000.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: ALU op codes, instruction
// opcodes, sequencer states and the decoded instruction classes.
package alu_ctrl_pkg;

  // ALU op codes driven on alu_op
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_MUL = 3'd3;
  localparam logic [2:0] ALU_DIV = 3'd4;
  localparam logic [2:0] ALU_MOD = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;

  // Instruction opcodes (8-bit encoding space)
  localparam logic [7:0] OPC_NOP       = 8'h00;
  localparam logic [7:0] OPC_ALU_FIRST = 8'h01;
  localparam logic [7:0] OPC_ALU_LAST  = 8'h06;
  localparam logic [7:0] OPC_LOAD      = 8'h10;
  localparam logic [7:0] OPC_STORE     = 8'h11;
  localparam logic [7:0] OPC_JMPZ      = 8'h20;
  localparam logic [7:0] OPC_JMPNZ     = 8'h21;
  localparam logic [7:0] OPC_JMP       = 8'h22;
  localparam logic [7:0] OPC_HALT      = 8'hFF;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    MEM,
    JUMP,
    HALT
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_JMPZ,
    CLS_JMPNZ,
    CLS_JMP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // Branch resolution for the jump classes against the registered z flag
  function automatic logic jump_taken(input op_class_e cls, input logic zf);
    case (cls)
      CLS_JMPZ:  return zf;
      CLS_JMPNZ: return !zf;
      CLS_JMP:   return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: classifies an opcode, extracts the ALU op for
// arithmetic instructions and flags opcodes outside the defined set.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W = 8
) (
  input  logic [OPC_W-1:0] opcode_i,
  output op_class_e        class_o,
  output logic [2:0]       alu_op_o,
  output logic             is_legal_o
);

  // Classify the opcode; anything not matched stays illegal
  always_comb begin
    class_o    = CLS_ILLEGAL;
    alu_op_o   = ALU_NOP;
    is_legal_o = 1'b0;
    if (opcode_i >= OPC_W'(OPC_ALU_FIRST) && opcode_i <= OPC_W'(OPC_ALU_LAST)) begin
      class_o    = CLS_ALU;
      alu_op_o   = opcode_i[2:0];
      is_legal_o = 1'b1;
    end else begin
      case (opcode_i)
        OPC_W'(OPC_NOP): begin
          class_o    = CLS_NOP;
          is_legal_o = 1'b1;
        end
        OPC_W'(OPC_LOAD): begin
          class_o    = CLS_LOAD;
          is_legal_o = 1'b1;
        end
        OPC_W'(OPC_STORE): begin
          class_o    = CLS_STORE;
          is_legal_o = 1'b1;
        end
        OPC_W'(OPC_JMPZ): begin
          class_o    = CLS_JMPZ;
          is_legal_o = 1'b1;
        end
        OPC_W'(OPC_JMPNZ): begin
          class_o    = CLS_JMPNZ;
          is_legal_o = 1'b1;
        end
        OPC_W'(OPC_JMP): begin
          class_o    = CLS_JMP;
          is_legal_o = 1'b1;
        end
        OPC_W'(OPC_HALT): begin
          class_o    = CLS_HALT;
          is_legal_o = 1'b1;
        end
        default: begin
          class_o    = CLS_ILLEGAL;
          is_legal_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Per-core control sequencer: fetches an opcode over a ready-handshake memory
// port, decodes it and steps the datapath (ALU, accumulator, PC) through the
// required states, registering the ALU z flag and counting retired instructions.
// Optional: define ALU_CTRL_SEQ_ILLEGAL_TRAP_EN to halt on undefined opcodes and
// expose a sticky illegal_op output; otherwise undefined opcodes act as NOP.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPC_W-1:0] instr,
  input  logic             z,
  input  logic             mem_ready,
  output logic [2:0]       alu_op,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             mem_ifetch,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ac_load,
  output logic             ac_src_mem,
  output logic             z_flag,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_op
`endif
);

  state_e           state_q, state_d;
  op_class_e        cls_q, cls_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  op_class_e        dec_cls;
  logic [2:0]       dec_alu_op;
  logic             dec_legal;

`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
  logic             illegal_q, illegal_d;
`endif

  alu_ctrl_decode #(
    .OPC_W(OPC_W)
  ) u_decode (
    .opcode_i  (instr),
    .class_o   (dec_cls),
    .alu_op_o  (dec_alu_op),
    .is_legal_o(dec_legal)
  );

  // Next-state, datapath strobes and retire pulse from the registered state
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_sel_d  = alu_sel_q;
    z_d        = z_q;
    retire     = 1'b0;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    alu_op     = ALU_NOP;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_ifetch = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    ac_load    = 1'b0;
    ac_src_mem = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end

      FETCH: begin
        mem_rd     = 1'b1;
        mem_ifetch = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end
      end

      // The decoded class and ALU op are captured here so the later states
      // depend only on registered values, not on instr staying stable.
      DECODE: begin
        cls_d     = dec_cls;
        alu_sel_d = dec_alu_op;
        if (!dec_legal) begin
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
          state_d   = HALT;
          illegal_d = 1'b1;
`else
          state_d = FETCH;
          retire  = 1'b1;
`endif
        end else begin
          case (dec_cls)
            CLS_ALU:             state_d = EXEC;
            CLS_LOAD, CLS_STORE: state_d = MEM;
            CLS_JMPZ, CLS_JMPNZ, CLS_JMP: begin
              if (jump_taken(dec_cls, z_q)) begin
                state_d = JUMP;
              end else begin
                state_d = FETCH;
                retire  = 1'b1;
              end
            end
            CLS_HALT: begin
              state_d = HALT;
              retire  = 1'b1;
            end
            default: begin
              state_d = FETCH;
              retire  = 1'b1;
            end
          endcase
        end
      end

      EXEC: begin
        alu_op  = alu_sel_q;
        state_d = WB;
      end

      WB: begin
        ac_load = 1'b1;
        z_d     = z;
        retire  = 1'b1;
        state_d = FETCH;
      end

      MEM: begin
        if (cls_q == CLS_STORE) mem_wr = 1'b1;
        else                    mem_rd = 1'b1;
        if (mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            ac_load    = 1'b1;
            ac_src_mem = 1'b1;
          end
          retire  = 1'b1;
          state_d = FETCH;
        end
      end

      JUMP: begin
        pc_load = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // State, captured decode, z flag and retire counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cls_q     <= CLS_NOP;
      alu_sel_q <= ALU_NOP;
      z_q       <= 1'b0;
      retired_q <= '0;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_sel_q <= alu_sel_d;
      z_q       <= z_d;
      retired_q <= retired_d;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy   = (state_q != IDLE) && (state_q != HALT);
    halted = (state_q == HALT);
  end

  assign z_flag  = z_q;
  assign retired = retired_q;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_q;
`endif

endmodule
